// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues requests to a 1-cycle
// synchronous instruction memory and buffers returned words in a 2-entry
// queue. Redirects flush the queue and bump an epoch so stale returns drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    logic [31:0] r_pc;
    logic        r_epoch;
    logic        r_inflight;
    logic        r_inflight_epoch;
    logic [31:0] r_inflight_pc;

    logic [31:0] r_q_inst [BUF_DEPTH];
    logic [31:0] r_q_pc   [BUF_DEPTH];
    logic        r_rd_ptr;
    logic        r_wr_ptr;
    logic [1:0]  r_count;

    logic        w_pop;
    logic        w_push;
    logic        w_issue;
    logic [1:0]  w_occ;
    logic        w_unused_addr_lsbs;

    // Redirect targets are forced to word alignment, so the low bits are dropped.
    assign w_unused_addr_lsbs = ^redirect_pc[1:0];

    // Occupancy counts queued words plus the word that will return next cycle;
    // capping it at two is what keeps a push from ever finding the queue full.
    assign w_occ   = r_count + {1'b0, r_inflight};
    assign w_pop   = inst_valid && inst_ready;
    assign w_push  = r_inflight && (r_inflight_epoch == r_epoch);
    assign w_issue = !reset && !redirect &&
                     ((w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop));

    assign imem_req   = w_issue;
    assign imem_addr  = r_pc;
    assign inst_valid = (r_count != 2'd0);
    assign inst       = r_q_inst[r_rd_ptr];
    assign inst_pc    = r_q_pc[r_rd_ptr];

    // PC, epoch and in-flight tracking; redirect outranks a normal issue.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_epoch          <= 1'b0;
            r_inflight       <= 1'b0;
            r_inflight_epoch <= 1'b0;
            r_inflight_pc    <= 32'h0;
        end else begin
            r_inflight <= w_issue;
            if (redirect) begin
                r_pc    <= {redirect_pc[31:2], 2'b00};
                r_epoch <= ~r_epoch;
            end else if (w_issue) begin
                r_pc             <= r_pc + 32'd4;
                r_inflight_pc    <= r_pc;
                r_inflight_epoch <= r_epoch;
            end
        end
    end

    // Instruction queue; a redirect empties it and discards any same-cycle return.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_q_inst[i] <= 32'h0;
                r_q_pc[i]   <= 32'h0;
            end
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else if (redirect) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_q_inst[r_wr_ptr] <= imem_rdata;
                r_q_pc[r_wr_ptr]   <= r_inflight_pc;
                r_wr_ptr           <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the single-cycle decode/register/ALU datapath and feeds it one 32-bit instruction word per handshake.
- Owns the architectural PC and drives a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry queue so downstream stalls never lose an instruction.
- Accepts taken-branch redirects from the datapath and flushes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- BUF_DEPTH, 2, instruction queue entries; fixed at 2, no other value supported.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- imem_req  output  1  fetch request issued this cycle
- imem_addr  output  32  byte address of request (= pc_q)
- imem_rdata  input  32  instruction word for the request issued in the previous cycle
- inst_valid  output  1  head of queue holds a valid instruction
- inst  output  32  head instruction word
- inst_pc  output  32  byte address of head instruction
- inst_ready  input  1  downstream accepts head this cycle
- redirect  input  1  taken branch; restart fetch at redirect_pc
- redirect_pc  input  32  branch target (byte address)

Behaviour:
- Reset (sampled on clk edge while reset=1):
  - pc_q=RESET_PC; queue empty (count=0); inflight=0; epoch=0.
  - Outputs: inst_valid=0; imem_req=0 while reset is high; inst and inst_pc read 0.
- Issue rule:
  - imem_req=1 when !reset && !redirect && (count+inflight < 2, or count+inflight == 2 with pop this cycle).
  - pop = inst_valid && inst_ready.
  - On issue: pc_q <= pc_q+4, mod 2^32, wraps 32'hFFFF_FFFC -> 0; inflight <= 1; inflight_pc <= pc_q; inflight_epoch <= epoch.
  - No issue: inflight <= 0; pc_q holds.
- Response: the cycle after an issue, imem_rdata is valid.
  - If inflight_epoch == epoch, push {imem_rdata, inflight_pc} into the queue.
  - Otherwise drop the word.
- Queue:
  - 2-entry FIFO; inst, inst_pc and inst_valid come straight from the head entry register, with no combinational path from imem_rdata.
  - Push and pop in the same cycle are both allowed; count stays unchanged.
  - The issue rule guarantees a push never hits a full queue. An overflow is a design error; the bench asserts on it.
- Latency: at least 2 cycles from an issue to inst_valid for that word, no bypass. After reset deassertion, the first inst_valid arrives on the 2nd rising edge.
- Throughput: 1 instruction/cycle when inst_ready is held high.
- Redirect (highest priority):
  - Cycle with redirect=1: pc_q <= {redirect_pc[31:2], 2'b00}; queue cleared (count <= 0); epoch toggles; no issue that cycle.
  - If inst_valid && inst_ready in the same cycle, the head counts as consumed; it belongs to the redirecting instruction.
  - An in-flight response returning in the next cycle carries the old epoch and is dropped.
  - First post-redirect issue happens the cycle after redirect; its inst_valid appears 2 cycles after that.
- Redirect on consecutive cycles: each one flushes; the last target wins.
- Redirect while reset=1: ignored, reset wins.
- Reset mid-operation: all state returns to reset values at the next edge. An in-flight word is discarded because inflight clears.
- inst_valid must stay high and inst/inst_pc stable until popped or flushed. There is no valid drop without a pop, redirect or reset.
- State summary:
  - pc_q[31:0], epoch, inflight, inflight_epoch, inflight_pc[31:0].
  - Queue storage: 2 x {inst[31:0], pc[31:0]}, rd/wr pointers, count[1:0].

Test Plan:
- Reset release, inst_ready=1, memory word at address A = 32'h2000_0000|A: imem_addr sequence 0,4,8,...; inst_valid first high 2 cycles after release; inst_pc=0, 4, 8 back-to-back with 1 instr/cycle.
- Backpressure: inst_ready=0 for 5 cycles after first valid. Required response:
  - Exactly 2 words buffered (pc 0, 4).
  - imem_req stays 0 once count+inflight=2.
  - On ready=1, pcs 0, 4, 8 delivered in order with no duplicates or gaps.
- Redirect while queue is full and a fetch is in flight, redirect_pc=32'h0000_0103. Required response:
  - Next cycle inst_valid=0.
  - imem_addr=32'h0000_0100; the stale response is not delivered.
  - The first post-redirect inst_pc=32'h100.
- Redirect in the same cycle as a pop, then redirect again the following cycle to 32'h200: only the 32'h200 stream appears; no word from 32'h100 is ever valid.
- PC wrap: RESET_PC=32'hFFFF_FFF8. Required response: inst_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Reset asserted for 1 cycle mid-stream with queue at count=1. Required response:
  - inst_valid=0 the cycle after.
  - Fetch restarts at RESET_PC.
  - No pre-reset word is delivered.
